// File: rtl/sram_ext_port_arbiter.sv
// rtl/sram_ext_port_arbiter.sv - round-robin arbiter sharing the SRAM wrapper external port
// Two-stage pipeline: accept -> SRAM enables (stage 1) -> tagged response (stage 2).
module sram_ext_port_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_wen,
    input  logic [N_REQ*64-1:0]     req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [63:0]             addr_ext,
    output logic                    wen_ext,
    output logic                    ren_ext,
    output logic [DATA_W-1:0]       wdata_ext,
    input  logic [DATA_W-1:0]       rdata_ext
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0]   r_ptr;
    logic              r_s1_valid;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s1_err;
    logic              r_wen_ext;
    logic              r_ren_ext;
    logic [63:0]       r_addr_ext;
    logic [DATA_W-1:0] r_wdata_ext;
    logic              r_s2_valid;
    logic [ID_W-1:0]   r_s2_id;
    logic              r_s2_err;
    logic              r_s2_rd;

    logic              w_found;
    logic [ID_W-1:0]   w_gnt_id;
    logic [63:0]       w_addr;
    logic              w_wen;
    logic              w_in_range;

    // Search starts at r_ptr and wraps, so the last-served requester goes last.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(idx);
            end
        end
    end

    assign w_addr     = req_addr[64*w_gnt_id +: 64];
    assign w_wen      = req_wen[w_gnt_id];
    assign w_in_range = (w_addr[63:ADDR_W+2] == '0) && (w_addr[1:0] == 2'b00);

    assign req_ready = (w_found && !rst) ? (N_REQ'(1) << w_gnt_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_err    <= 1'b0;
            r_wen_ext   <= 1'b0;
            r_ren_ext   <= 1'b0;
            r_addr_ext  <= '0;
            r_wdata_ext <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_id     <= '0;
            r_s2_err    <= 1'b0;
            r_s2_rd     <= 1'b0;
        end else begin
            if (w_found) begin
                r_ptr       <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
                r_s1_valid  <= 1'b1;
                r_s1_id     <= w_gnt_id;
                r_s1_err    <= ~w_in_range;
                r_wen_ext   <= w_wen & w_in_range;
                r_ren_ext   <= ~w_wen & w_in_range;
                r_addr_ext  <= w_addr;
                r_wdata_ext <= req_wdata[DATA_W*w_gnt_id +: DATA_W];
            end else begin
                r_s1_valid  <= 1'b0;
                r_wen_ext   <= 1'b0;
                r_ren_ext   <= 1'b0;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_err   <= r_s1_err;
            r_s2_rd    <= r_ren_ext;
        end
    end

    // Gating by rst keeps a stage-1 access from landing in the SRAM during reset.
    assign wen_ext   = r_wen_ext & ~rst;
    assign ren_ext   = r_ren_ext & ~rst;
    assign addr_ext  = r_addr_ext;
    assign wdata_ext = r_wdata_ext;

    assign rsp_valid = r_s2_valid ? (N_REQ'(1) << r_s2_id) : '0;
    assign rsp_err   = r_s2_valid & r_s2_err;
    assign rsp_rdata = (r_s2_valid && r_s2_rd) ? rdata_ext : '0;
endmodule
